// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: bus widths and fetch
// exception codes.
package inst_fetch_queue_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef logic [4:0] exccode_t;

  localparam exccode_t EXC_INT  = 5'h00;
  localparam exccode_t EXC_TLBL = 5'h02;
  localparam exccode_t EXC_TLBS = 5'h03;
  localparam exccode_t EXC_ADEL = 5'h04;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// I-side bus between the fetch queue (master) and the cache/bus (slave):
// request/address-accept handshake plus in-order data return.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_fetch_queue_slot_ram.sv
// Slot payload storage: one write port for reserve/push, one for response
// fill, asynchronous read at the head slot.
module fq_slot_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              wr_exc,
  input  exccode_t          wr_exccode,
  input  logic              fill_en,
  input  logic [PTR_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_inst,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_inst,
  output logic              rd_exc,
  output exccode_t          rd_exccode
);

  logic [ADDR_W-1:0] pc_mem      [DEPTH];
  logic [DATA_W-1:0] inst_mem    [DEPTH];
  logic              exc_mem     [DEPTH];
  exccode_t          exccode_mem [DEPTH];

  // Reserve and fill never target the same slot (tail is free, fill is reserved).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]      <= wr_pc;
      inst_mem[wr_idx]    <= '0;
      exc_mem[wr_idx]     <= wr_exc;
      exccode_mem[wr_idx] <= wr_exccode;
    end
    if (fill_en) begin
      inst_mem[fill_idx] <= fill_inst;
    end
  end

  assign rd_pc      = pc_mem[rd_idx];
  assign rd_inst    = inst_mem[rd_idx];
  assign rd_exc     = exc_mem[rd_idx];
  assign rd_exccode = exccode_mem[rd_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch queue between PC generation and decode: pipelines up to DEPTH I-side
// requests, pairs in-order responses with PCs, discards responses after flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  input  logic [ADDR_W-1:0]    req_pc_i,
  input  logic                 req_exc_i,
  input  exccode_t             req_exccode_i,
  output logic                 req_ready_o,
  inst_fetch_queue_if.master   bus,
  output logic                 valid_o,
  output logic [ADDR_W-1:0]    pc_o,
  output logic [DATA_W-1:0]    inst_o,
  output logic                 exc_o,
  output exccode_t             exccode_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, tail_q, fill_q;
  logic [CNT_W-1:0] count_q, pending_q, discard_q;
  logic [DEPTH-1:0] used_q, filled_q;

  logic             not_full, issue, reserve, push_exc, fill, drop, pop;
  logic [CNT_W:0]   outstanding;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic              rd_exc;
  exccode_t          rd_exccode;

  always_comb begin
    not_full    = count_q < CNT_FULL;
    outstanding = {1'b0, pending_q} + {1'b0, discard_q};
    issue       = req_valid_i & ~req_exc_i & ~flush_i & not_full
                  & (outstanding < (CNT_W+1)'(DEPTH));
    reserve     = issue & bus.inst_addr_ok;
    // Exception entries wait for all bus traffic to drain so order is kept.
    push_exc    = req_valid_i & req_exc_i & ~flush_i & not_full
                  & (pending_q == '0) & (discard_q == '0);
    drop        = bus.inst_data_ok & (discard_q != '0);
    fill        = bus.inst_data_ok & (discard_q == '0) & (pending_q != '0);
    valid_o     = used_q[head_q] & filled_q[head_q];
    pop         = valid_o & ready_i;
  end

  assign bus.inst_req  = issue;
  assign bus.inst_addr = req_pc_i;
  assign req_ready_o   = reserve | push_exc;
  assign count_o       = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      used_q    <= '0;
      filled_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      discard_q <= '0;
    end else if (flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      used_q    <= '0;
      filled_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      // A response landing in the flush cycle already settles one owed slot.
      discard_q <= discard_q + pending_q
                   - CNT_W'(bus.inst_data_ok && (outstanding != '0));
    end else begin
      if (reserve | push_exc) begin
        used_q[tail_q]   <= 1'b1;
        filled_q[tail_q] <= push_exc;
        tail_q           <= tail_q + PTR_ONE;
      end
      if (fill) begin
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + PTR_ONE;
      end
      if (pop) begin
        used_q[head_q]   <= 1'b0;
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + PTR_ONE;
      end
      count_q   <= count_q + CNT_W'(reserve | push_exc) - CNT_W'(pop);
      pending_q <= pending_q + CNT_W'(reserve) - CNT_W'(fill);
      if (drop) begin
        discard_q <= discard_q - CNT_ONE;
      end
    end
  end

  fq_slot_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot_ram (
    .clk        (clk),
    .wr_en      (reserve | push_exc),
    .wr_idx     (tail_q),
    .wr_pc      (req_pc_i),
    .wr_exc     (push_exc),
    .wr_exccode (push_exc ? req_exccode_i : EXC_INT),
    .fill_en    (fill),
    .fill_idx   (fill_q),
    .fill_inst  (bus.inst_rdata),
    .rd_idx     (head_q),
    .rd_pc      (rd_pc),
    .rd_inst    (rd_inst),
    .rd_exc     (rd_exc),
    .rd_exccode (rd_exccode)
  );

  // Payload is only meaningful under valid_o; keep it at zero otherwise.
  assign pc_o      = valid_o ? rd_pc      : '0;
  assign inst_o    = valid_o ? rd_inst    : '0;
  assign exc_o     = valid_o & rd_exc;
  assign exccode_o = valid_o ? rd_exccode : EXC_INT;

endmodule
